fetch_ctrl: RTL

Instruction-fetch controller that sequences the combinational, word-indexed instruction memory. Holds the program counter, drives the memory address each cycle, and buffers fetched words with their PCs in a small prefetch FIFO. Delivers them to decode over a valid/ready handshake. Accepts redirects (branch, jump, `jal`, `jr`) that flush the buffer and restart fetch.

---
 rtl/fetch_ctrl_if.sv | 50 +++++
 rtl/fetch_ctrl.sv | 121 ++++++++++++
 2 files changed

// File: rtl/fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// fetch_ctrl_if: bundle of the instruction-fetch controller's bus signals.
//
//   Instruction memory : imem_addr (word index out), imem_data (word in)
//   Redirect / control : redirect_valid, redirect_pc, halt
//   Decode handshake   : out_valid, out_ready, out_inst, out_pc
//   Status             : fault
//
// Modports:
//   master - the fetch controller side (drives address, decode data, fault)
//   slave  - the environment side (memory, redirect source, decode stage)
// -----------------------------------------------------------------------------
interface fetch_ctrl_if;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halt;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic [31:0] out_pc;
   logic        fault;

   modport master (
      output imem_addr,
      input  imem_data,
      input  redirect_valid,
      input  redirect_pc,
      input  halt,
      output out_valid,
      input  out_ready,
      output out_inst,
      output out_pc,
      output fault
   );

   modport slave (
      input  imem_addr,
      output imem_data,
      output redirect_valid,
      output redirect_pc,
      output halt,
      input  out_valid,
      output out_ready,
      input  out_inst,
      input  out_pc,
      input  fault
   );
endinterface

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl: instruction-fetch controller for a combinational, word-indexed
// instruction memory.
//
// Holds the program counter (a word index), presents it as the memory address
// every cycle and pushes {instruction, pc} into a small circular prefetch FIFO.
// The FIFO head is offered to decode over a valid/ready handshake. A redirect
// flushes the FIFO and reloads the PC; halt stops new fetches while the FIFO
// keeps draining; fault flags a PC outside the valid memory range and stops
// fetch until a redirect back into range.
//
// Parameters:
//   DEPTH     - prefetch FIFO entries (power of two, >= 2)
//   RESET_PC  - word index fetched first after reset
//   MEM_WORDS - number of valid instruction-memory words
//
// Ports:
//   clk      - single clock, all state on the rising edge
//   reset_n  - asynchronous active-low reset
//   bus      - fetch_ctrl_if.master (memory, redirect/halt, decode, fault)
//
// Optional feature (macro FETCH_PERF_EN):
//   perf_fetched   - 32-bit count of FIFO pushes (wraps)
//   perf_redirects - 32-bit count of redirect cycles (wraps)
// -----------------------------------------------------------------------------
module fetch_ctrl #(
   parameter int unsigned DEPTH     = 2,
   parameter logic [31:0] RESET_PC  = 32'd0,
   parameter int unsigned MEM_WORDS = 65
) (
   input  logic          clk,
   input  logic          reset_n,
   fetch_ctrl_if.master  bus
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]   perf_fetched,
   output logic [31:0]   perf_redirects
`endif
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [31:0]   pc;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [CW-1:0] count;
   logic [31:0]   buf_inst [DEPTH];
   logic [31:0]   buf_pc   [DEPTH];

   logic fault;
   logic pop;
   logic push;

   // Redirect wins over everything; a full FIFO may still accept a word when
   // the head leaves in the same cycle, so steady state has no bubble.
   always_comb begin
      fault = (pc >= 32'(MEM_WORDS));
      pop   = (count != '0) && bus.out_ready;
      push  = !bus.redirect_valid && !bus.halt && !fault &&
              ((count < CW'(DEPTH)) || pop);
   end

   assign bus.imem_addr = pc;
   assign bus.fault     = fault;
   assign bus.out_valid = (count != '0);
   assign bus.out_inst  = buf_inst[rd_ptr];
   assign bus.out_pc    = buf_pc[rd_ptr];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc     <= RESET_PC;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         // NOTE: the FIFO storage is reset because out_inst/out_pc must read 0
         // out of reset; it is only DEPTH entries, so a plain flop reset is fine.
         for (int i = 0; i < DEPTH; i++) begin
            buf_inst[i] <= '0;
            buf_pc[i]   <= '0;
         end
      end else if (bus.redirect_valid) begin
         // A pop handshake in this cycle completes at decode's side; the
         // flush simply discards whatever is left.
         pc     <= bus.redirect_pc;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         // NOTE: non-blocking assignments throughout so every register here
         // sees the pre-edge values of its neighbours, independent of order.
         if (push) begin
            buf_inst[wr_ptr] <= bus.imem_data;
            buf_pc[wr_ptr]   <= pc;
            wr_ptr           <= wr_ptr + AW'(1);
            pc               <= pc + 32'd1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + CW'(push) - CW'(pop);
      end
   end

`ifdef FETCH_PERF_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         perf_fetched   <= '0;
         perf_redirects <= '0;
      end else begin
         if (push) begin
            perf_fetched <= perf_fetched + 32'd1;
         end
         if (bus.redirect_valid) begin
            perf_redirects <= perf_redirects + 32'd1;
         end
      end
   end
`endif

endmodule
